// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with an internal byte FIFO
// Frames are fed back-to-back from the FIFO; tx and tx_busy are registered outputs.
module uart_tx #(
  parameter int CLK_DIV         = 104,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 tx_byte,
  input  logic                       tx_send,
  output logic                       tx_full,
  output logic                       tx_empty,
  output logic [FIFO_DEPTH_LOG2:0]   tx_count,
  output logic                       tx_busy,
  output logic                       tx
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;

  localparam logic [BAUD_W-1:0]          BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0]          BAUD_ONE  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]           CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           count_d;
  logic                       full_q;
  logic                       empty_q;

  state_e                     state_q;
  logic [BAUD_W-1:0]          baud_q;
  logic [2:0]                 bit_idx_q;
  logic [7:0]                 shift_q;
  logic                       tx_q;
  logic                       busy_q;

  logic                       push;
  logic                       pop;
  logic                       baud_tc;

  always_comb begin
    baud_tc = (baud_q == BAUD_LAST);
    // full is the registered flag, so a write at full is dropped even when a pop happens this cycle
    push    = tx_send & ~full_q;
    pop     = ~empty_q & ((state_q == IDLE) | ((state_q == STOP) & baud_tc));
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a line-decoding monitor
// Expected bytes are queued as stimulus is driven and compared as frames are decoded.
module tb_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int LOG2    = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          tx_send = 1'b0;
  logic          tx_full;
  logic          tx_empty;
  logic [LOG2:0] tx_count;
  logic          tx_busy;
  logic          tx;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_byte  (tx_byte),
    .tx_send  (tx_send),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_count (tx_count),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Samples every bit-cell cycle of a frame; a frame cut by reset is discarded.
  initial begin : monitor
    logic       s [FRAME];
    logic [7:0] b;
    logic       expbit;
    int         bad;
    int         seg;
    int         start_cyc;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        aborted   = 1'b0;
        s[0]      = tx;
        start_cyc = cyc;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[k] = tx;
        end
        if (!aborted) begin
          frames++;
          start_q.push_back(start_cyc);
          for (int i = 0; i < 8; i++) b[i] = s[CLK_DIV * (i + 1) + CLK_DIV / 2];
          bad = 0;
          for (int k = 0; k < FRAME; k++) begin
            seg    = k / CLK_DIV;
            expbit = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : b[seg - 1];
            if (s[k] !== expbit) bad++;
          end
          check("frame_shape", 32'(bad), 32'd0);
          if (exp_q.size() > 0) check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
          else                  check("unexpected_frame", 32'(b), 32'h100);
        end
      end
    end
  end

  initial begin : main
    int viol;
    int maxc;
    int f0;
    int expc;

    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(tx),       32'd1);
    check("rst_busy",  32'(tx_busy),  32'd0);
    check("rst_empty", 32'(tx_empty), 32'd1);
    check("rst_full",  32'(tx_full),  32'd0);
    check("rst_count", 32'(tx_count), 32'd0);
    reset_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1 || tx_count !== '0) viol++;
    end
    check("idle_hold", 32'(viol), 32'd0);

    // single byte latency and frame length
    exp_q.push_back(8'h55);
    @(negedge clk); tx_byte = 8'h55; tx_send = 1'b1;
    @(negedge clk); tx_send = 1'b0;
    check("lat_empty", 32'(tx_empty), 32'd0);
    check("lat_count", 32'(tx_count), 32'd1);
    check("lat_tx_hi", 32'(tx),       32'd1);
    @(negedge clk);
    check("lat_tx_lo", 32'(tx),       32'd0);
    check("lat_busy",  32'(tx_busy),  32'd1);
    check("lat_pop",   32'(tx_count), 32'd0);
    repeat (39) @(negedge clk);
    check("stop_busy", 32'(tx_busy), 32'd1);
    check("stop_tx",   32'(tx),      32'd1);
    @(negedge clk);
    check("busy_fall", 32'(tx_busy), 32'd0);
    repeat (5) @(negedge clk);

    // back-to-back frames
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    @(negedge clk); tx_byte = 8'hA5; tx_send = 1'b1;
    @(negedge clk); tx_byte = 8'h3C;
    @(negedge clk); tx_send = 1'b0;
    repeat (50) @(negedge clk);
    check("b2b_empty", 32'(tx_empty), 32'd1);
    check("b2b_busy",  32'(tx_busy),  32'd1);
    repeat (40) @(negedge clk);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    check("b2b_idle", 32'(tx_busy), 32'd0);

    // overflow: 18 writes, 17 accepted
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        expc = (i <= 2) ? 1 : ((i - 1 > 16) ? 16 : i - 1);
        check("ovf_count", 32'(tx_count), 32'(expc));
        check("ovf_full",  32'(tx_full),  32'(expc == 16));
      end
      if (i < 18) begin
        tx_byte = 8'(i);
        tx_send = 1'b1;
      end else begin
        tx_send = 1'b0;
      end
    end
    maxc = 0;
    repeat (17 * FRAME + 20) begin
      @(negedge clk);
      if (int'(tx_count) > maxc) maxc = int'(tx_count);
    end
    check("ovf_max",     32'(maxc),         32'd16);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_empty",   32'(tx_empty),     32'd1);
    check("ovf_idle",    32'(tx_busy),      32'd0);

    // simultaneous push and pop, in IDLE and at STOP terminal count
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'hC3);
    @(negedge clk); tx_byte = 8'h81; tx_send = 1'b1;
    @(negedge clk); tx_byte = 8'h7E;
    check("pp_count0", 32'(tx_count), 32'd1);
    @(negedge clk); tx_send = 1'b0;
    check("pp_count1", 32'(tx_count), 32'd1);
    repeat (39) @(negedge clk);
    tx_byte = 8'hC3; tx_send = 1'b1;
    check("pp_stop_tx",  32'(tx),       32'd1);
    check("pp_count2",   32'(tx_count), 32'd1);
    @(negedge clk); tx_send = 1'b0;
    check("pp_count3",   32'(tx_count), 32'd1);
    check("pp_start_tx", 32'(tx),       32'd0);
    repeat (3 * FRAME) @(negedge clk);
    check("pp_drained", 32'(exp_q.size()), 32'd0);

    // reset during data bit 3 with bytes queued
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); tx_byte = 8'(8'h11 + i); tx_send = 1'b1;
    end
    @(negedge clk); tx_send = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_count", 32'(tx_count), 32'd4);
    check("mid_busy",  32'(tx_busy),  32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_tx",    32'(tx),       32'd1);
    check("arst_count", 32'(tx_count), 32'd0);
    check("arst_busy",  32'(tx_busy),  32'd0);
    check("arst_empty", 32'(tx_empty), 32'd1);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    f0   = frames;
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    check("post_rst_quiet",  32'(viol),         32'd0);
    check("post_rst_frames", 32'(frames - f0),  32'd0);
    check("final_queue",     32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
